axi_port_arbiter: RTL
=====================

Name: axi_port_arbiter

Overview:
- Shares the single AXI-lite memory/IO master between two requesters: port 0 (instruction fetch) and port 1 (load/store unit).
- Grants one transaction at a time using round-robin and drives the master's command interface (address, op, data, active pulse).
- Waits for read-data-valid or write-response completion, then returns data or a completion pulse to the granted requester.
- Includes a watchdog timeout so a hung slave cannot lock the core.

Parameters:
TIMEOUT_CYCLES, 256, wait-state cycles before a transaction aborts with error; 0 disables the watchdog.
TO_W, 9, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
axi_aclk_i  in  1  clock
axi_aresetn_i  in  1  reset; asynchronous, active-low
p0_istek_i  in  1  port 0 request; held with its fields until p0_gecerli_o or p0_hata_o
p0_adres_i  in  32  port 0 address
p0_buyruk_turu_i  in  3  port 0 op (MEM_LB/LBU/LH/LHU/LW/SB/SH/SW)
p0_veri_i  in  32  port 0 store data
p0_kabul_o  out  1  one-cycle pulse: port 0 request latched and issued
p0_veri_o  out  32  port 0 read data; valid with p0_gecerli_o
p0_gecerli_o  out  1  one-cycle pulse: port 0 transaction complete
p0_hata_o  out  1  one-cycle pulse: port 0 transaction aborted (timeout or illegal op)
p1_* (istek_i, adres_i, buyruk_turu_i, veri_i, kabul_o, veri_o, gecerli_o, hata_o)  same as p0, for port 1
m_address_o  out  32  command address to master
m_buyruk_turu_o  out  3  command op to master
m_data_o  out  32  command store data to master
m_giris_cikis_aktif_o  out  1  one-cycle command strobe to master
m_okunan_veri_i  in  32  master read data (already sign/zero extended)
m_okunan_veri_gecerli_i  in  1  master read complete
m_yazma_tamam_i  in  1  write response received (bvalid & bready)
mesgul_o  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (async, active-low): state=IDLE, all outputs 0, latched command regs 0, timeout counter 0, last_grant=1 (port 0 wins first contention).
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- States: IDLE, ISSUE, WAIT_RD, WAIT_WR, RESP.
- IDLE:
  - If any istek is high, select a winner: a lone requester wins; if both request, the port != last_grant wins.
  - Latch winner id, adres, buyruk_turu and veri; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - m_giris_cikis_aktif_o=1 with the latched fields on m_*; winner's kabul_o=1.
  - Load op -> WAIT_RD; store op -> WAIT_WR.
  - Illegal op code: no strobe, kabul_o=1, set error flag, go directly to RESP.
- m_* fields are driven from the latched registers only during ISSUE and are 0 otherwise.
- WAIT_RD:
  - On m_okunan_veri_gecerli_i, capture m_okunan_veri_i and go to RESP.
  - m_yazma_tamam_i is ignored.
- WAIT_WR:
  - On m_yazma_tamam_i, go to RESP; response data is 0.
  - m_okunan_veri_gecerli_i is ignored.
- Watchdog:
  - The counter clears on entering a WAIT state and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES-1 with no completion, set error flag, data=0, go to RESP.
  - If completion and timeout occur in the same cycle, completion wins.
- RESP (exactly 1 cycle):
  - Winner's gecerli_o=1 (no error) or hata_o=1 (error), never both.
  - Winner's veri_o holds the captured data this cycle, else 0.
  - last_grant <= winner; return to IDLE.
- Latency: request sampled at edge T -> ISSUE cycle T+1 -> earliest RESP T+3 (completion in the first WAIT cycle).
- Completion inputs arriving in IDLE, ISSUE or RESP are ignored.
- A requester deasserting istek mid-transaction does not cancel it; the response pulse is still delivered.
- Back-to-back: a requester may keep istek high after its response to start a new transaction; round-robin then favours the other port if it is waiting.
- Reset mid-transaction: immediate return to IDLE; no response pulse is generated for the killed transaction.

Decomposition:
- Shared package/header:
  - the 3-bit MEM_* op codes from operations.vh
  - is_load / is_store / is_legal_op functions
  - state encoding localparams
- Sub-module rr_arbiter2: 2-input round-robin grant logic, with requests and last_grant in, one-hot grant out.

Test Plan:
- Port 0 only, LW 0x0000_1000; master returns 0xDEAD_BEEF one cycle after strobe -> strobe in cycle T+1, p0_gecerli_o and p0_veri_o=0xDEAD_BEEF in cycle T+3, mesgul_o low in T+4.
- Both ports request in the same cycle from reset (p0 LW, p1 SW 0x10 data 0x55) -> p0 served first, then p1; p1 strobe carries m_data_o=0x55 and m_buyruk_turu_o=SW; p1 gets gecerli after m_yazma_tamam_i.
- Both ports hold requests continuously for 4 transactions -> grants alternate p0,p1,p0,p1.
- TIMEOUT_CYCLES=8, p1 LB with no completion -> p1_hata_o exactly 8 cycles after the first WAIT cycle, p1_veri_o=0, then IDLE; a late m_okunan_veri_gecerli_i is ignored.
- Illegal op on p0 -> no m_giris_cikis_aktif_o; p0_kabul_o, then p0_hata_o in the next cycle.
- Reset asserted during WAIT_WR -> all outputs 0 asynchronously; after release, a p1-only request is granted normally and a stray m_yazma_tamam_i in IDLE has no effect.

Source files
------------

// File: rtl/axi_port_arbiter_pkg.sv
// Shared definitions for the two-port AXI-lite arbiter: memory op codes,
// op classification helpers and the controller state encoding.
package axi_port_arbiter_pkg;

    localparam logic [2:0] MEM_LB  = 3'd0;
    localparam logic [2:0] MEM_LBU = 3'd1;
    localparam logic [2:0] MEM_LH  = 3'd2;
    localparam logic [2:0] MEM_LHU = 3'd3;
    localparam logic [2:0] MEM_LW  = 3'd4;
    localparam logic [2:0] MEM_SB  = 3'd5;
    localparam logic [2:0] MEM_SH  = 3'd6;
    localparam logic [2:0] MEM_SW  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT_RD = 3'd2,
        S_WAIT_WR = 3'd3,
        S_RESP    = 3'd4
    } arb_state_e;

    function automatic logic is_load(input logic [2:0] op);
        return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
               (op == MEM_LHU) || (op == MEM_LW);
    endfunction

    function automatic logic is_store(input logic [2:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    // The mask lets an integration disable op codes the attached slave cannot serve.
    function automatic logic is_legal_op(input logic [2:0] op, input logic [7:0] mask);
        return mask[op] && (is_load(op) || is_store(op));
    endfunction

endpackage

// File: rtl/axi_port_arbiter_rr_arbiter2.sv
// Two-input round-robin grant: a lone requester wins, on contention the port
// that was not granted last time wins. One-hot grant out.
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_grant_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/axi_port_arbiter.sv
// Shares one AXI-lite command master between the fetch port (0) and the
// load/store port (1), one transaction at a time, with a wait-state watchdog.
module axi_port_arbiter
    import axi_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned TO_W           = 9,
    parameter logic [7:0]  LEGAL_OP_MASK  = 8'hFF
) (
    input  logic        axi_aclk_i,
    input  logic        axi_aresetn_i,

    input  logic        p0_istek_i,
    input  logic [31:0] p0_adres_i,
    input  logic [2:0]  p0_buyruk_turu_i,
    input  logic [31:0] p0_veri_i,
    output logic        p0_kabul_o,
    output logic [31:0] p0_veri_o,
    output logic        p0_gecerli_o,
    output logic        p0_hata_o,

    input  logic        p1_istek_i,
    input  logic [31:0] p1_adres_i,
    input  logic [2:0]  p1_buyruk_turu_i,
    input  logic [31:0] p1_veri_i,
    output logic        p1_kabul_o,
    output logic [31:0] p1_veri_o,
    output logic        p1_gecerli_o,
    output logic        p1_hata_o,

    output logic [31:0] m_address_o,
    output logic [2:0]  m_buyruk_turu_o,
    output logic [31:0] m_data_o,
    output logic        m_giris_cikis_aktif_o,
    input  logic [31:0] m_okunan_veri_i,
    input  logic        m_okunan_veri_gecerli_i,
    input  logic        m_yazma_tamam_i,

    output logic        mesgul_o
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    arb_state_e      state_q, state_d;
    logic            winner_q, winner_d;
    logic            last_grant_q, last_grant_d;
    logic [31:0]     adres_q, adres_d;
    logic [2:0]      op_q, op_d;
    logic [31:0]     veri_q, veri_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    logic [1:0]      gnt;
    logic            timed_out;

    rr_arbiter2 u_rr (
        .req_i        ({p1_istek_i, p0_istek_i}),
        .last_grant_i (last_grant_q),
        .gnt_o        (gnt)
    );

    assign timed_out = (TIMEOUT_CYCLES != 0) && (to_cnt_q == TO_LAST);

    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        last_grant_d = last_grant_q;
        adres_d      = adres_q;
        op_d         = op_q;
        veri_d       = veri_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        to_cnt_d     = to_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (gnt != 2'b00) begin
                    winner_d = gnt[1];
                    adres_d  = gnt[1] ? p1_adres_i       : p0_adres_i;
                    op_d     = gnt[1] ? p1_buyruk_turu_i : p0_buyruk_turu_i;
                    veri_d   = gnt[1] ? p1_veri_i        : p0_veri_i;
                    rdata_d  = '0;
                    err_d    = 1'b0;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                to_cnt_d = '0;
                if (!is_legal_op(op_q, LEGAL_OP_MASK)) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else if (is_load(op_q)) begin
                    state_d = S_WAIT_RD;
                end else begin
                    state_d = S_WAIT_WR;
                end
            end
            S_WAIT_RD: begin
                // Completion is checked before the watchdog so it wins a tie.
                if (m_okunan_veri_gecerli_i) begin
                    rdata_d = m_okunan_veri_i;
                    state_d = S_RESP;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_RESP;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_WAIT_WR: begin
                if (m_yazma_tamam_i) begin
                    state_d = S_RESP;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                last_grant_d = winner_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk_i or negedge axi_aresetn_i) begin
        if (!axi_aresetn_i) begin
            state_q      <= S_IDLE;
            winner_q     <= 1'b0;
            last_grant_q <= 1'b1;
            adres_q      <= '0;
            op_q         <= '0;
            veri_q       <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            to_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            last_grant_q <= last_grant_d;
            adres_q      <= adres_d;
            op_q         <= op_d;
            veri_q       <= veri_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            to_cnt_q     <= to_cnt_d;
        end
    end

    logic in_issue, in_resp;
    assign in_issue = (state_q == S_ISSUE);
    assign in_resp  = (state_q == S_RESP);

    assign m_address_o           = in_issue ? adres_q : '0;
    assign m_buyruk_turu_o       = in_issue ? op_q    : '0;
    assign m_data_o              = in_issue ? veri_q  : '0;
    assign m_giris_cikis_aktif_o = in_issue && is_legal_op(op_q, LEGAL_OP_MASK);

    assign p0_kabul_o   = in_issue && !winner_q;
    assign p1_kabul_o   = in_issue &&  winner_q;
    assign p0_gecerli_o = in_resp && !winner_q && !err_q;
    assign p1_gecerli_o = in_resp &&  winner_q && !err_q;
    assign p0_hata_o    = in_resp && !winner_q &&  err_q;
    assign p1_hata_o    = in_resp &&  winner_q &&  err_q;
    assign p0_veri_o    = (in_resp && !winner_q) ? rdata_q : '0;
    assign p1_veri_o    = (in_resp &&  winner_q) ? rdata_q : '0;

    assign mesgul_o = (state_q != S_IDLE);

endmodule
